// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game sequencer.
// Runs the IDLE -> CLEAR -> PLAY -> OVER flow and generates the pipe and
// bird movement ticks and the flap response. It also keeps a saturating
// 3-digit BCD score and the best score since reset.
// Every output comes straight from a flop, so downstream shifters see clean
// one-cycle pulses that line up with the state register.

module flappy_game_ctrl #(
  parameter int PIPE_DIV  = 176,
  parameter int BIRD_DIV  = 100,
  parameter int OVER_HOLD = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flap,
  input  logic        point,
  input  logic        loser,
  output logic        run,
  output logic        game_over,
  output logic        clear_board,
  output logic        pipe_tick,
  output logic        bird_tick,
  output logic        bird_up,
  output logic [11:0] score,
  output logic [11:0] hi_score
);

  // Divider widths follow the parameter. They are kept at least one bit wide
  // so that a degenerate divide-by-1 still elaborates.
  localparam int PIPE_W = (PIPE_DIV > 1) ? $clog2(PIPE_DIV) : 1;
  localparam int BIRD_W = (BIRD_DIV > 1) ? $clog2(BIRD_DIV) : 1;
  localparam int HOLD_W = $clog2(OVER_HOLD) + 1;

  localparam logic [PIPE_W-1:0] PIPE_MAX = PIPE_W'(PIPE_DIV - 1);
  localparam logic [BIRD_W-1:0] BIRD_MAX = BIRD_W'(BIRD_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(OVER_HOLD);
  localparam logic [11:0]       SCORE_MAX = 12'h999;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [PIPE_W-1:0]   pipe_cnt_r;
  logic [PIPE_W-1:0]   pipe_cnt_nxt_s;
  logic [BIRD_W-1:0]   bird_cnt_r;
  logic [BIRD_W-1:0]   bird_cnt_nxt_s;
  logic [HOLD_W-1:0]   hold_cnt_r;
  logic [HOLD_W-1:0]   hold_cnt_nxt_s;
  logic [11:0]         score_r;
  logic [11:0]         score_nxt_s;
  logic [11:0]         hi_score_r;
  logic [11:0]         hi_score_nxt_s;
  logic                point_q_r;
  logic                pipe_tick_nxt_s;
  logic                bird_tick_nxt_s;
  logic                bird_up_nxt_s;
  logic                run_r;
  logic                game_over_r;
  logic                clear_board_r;
  logic                pipe_tick_r;
  logic                bird_tick_r;
  logic                bird_up_r;
  logic                point_rise_s;
  logic                pipe_wrap_s;
  logic                bird_wrap_s;
  logic                hold_done_s;

  // BCD increment with ripple carry from ones to hundreds. 999 holds.
  function automatic logic [11:0] bcd_inc(input logic [11:0] value);
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    d0 = value[3:0];
    d1 = value[7:4];
    d2 = value[11:8];
    if (value == SCORE_MAX) begin
      d0 = value[3:0];
    end else if (d0 != 4'd9) begin
      d0 = d0 + 4'd1;
    end else begin
      d0 = 4'd0;
      if (d1 != 4'd9) begin
        d1 = d1 + 4'd1;
      end else begin
        d1 = 4'd0;
        d2 = d2 + 4'd1;
      end
    end
    return {d2, d1, d0};
  endfunction

  assign point_rise_s = point & ~point_q_r;
  assign pipe_wrap_s  = (pipe_cnt_r == PIPE_MAX);
  assign bird_wrap_s  = (bird_cnt_r == BIRD_MAX);
  assign hold_done_s  = (hold_cnt_r >= HOLD_MAX);

  // Next-state, counter and pulse decode for the game flow.
  always_comb begin
    state_nxt_s     = state_r;
    pipe_cnt_nxt_s  = pipe_cnt_r;
    bird_cnt_nxt_s  = bird_cnt_r;
    hold_cnt_nxt_s  = {HOLD_W{1'b0}};
    score_nxt_s     = score_r;
    hi_score_nxt_s  = hi_score_r;
    pipe_tick_nxt_s = 1'b0;
    bird_tick_nxt_s = 1'b0;
    bird_up_nxt_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (flap) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        // The board is wiped in this cycle, so the flap input is not looked at.
        state_nxt_s    = ST_PLAY;
        score_nxt_s    = 12'h000;
        pipe_cnt_nxt_s = {PIPE_W{1'b0}};
        bird_cnt_nxt_s = {BIRD_W{1'b0}};
      end

      ST_PLAY: begin
        if (loser) begin
          // A collision overrides a point in the same cycle. The best score is
          // captured on the way out, while the score is final.
          state_nxt_s = ST_OVER;
          if (score_r > hi_score_r) begin
            hi_score_nxt_s = score_r;
          end else begin
            hi_score_nxt_s = hi_score_r;
          end
        end else begin
          state_nxt_s = ST_PLAY;
          if (point_rise_s) begin
            score_nxt_s = bcd_inc(score_r);
          end else begin
            score_nxt_s = score_r;
          end

          if (pipe_wrap_s) begin
            pipe_cnt_nxt_s  = {PIPE_W{1'b0}};
            pipe_tick_nxt_s = 1'b1;
          end else begin
            pipe_cnt_nxt_s  = pipe_cnt_r + PIPE_W'(1);
          end

          // A flap restarts the gravity period and wins over a wrap in the same cycle.
          if (flap) begin
            bird_cnt_nxt_s = {BIRD_W{1'b0}};
            bird_up_nxt_s  = 1'b1;
          end else if (bird_wrap_s) begin
            bird_cnt_nxt_s  = {BIRD_W{1'b0}};
            bird_tick_nxt_s = 1'b1;
          end else begin
            bird_cnt_nxt_s = bird_cnt_r + BIRD_W'(1);
          end
        end
      end

      ST_OVER: begin
        if (hold_done_s && flap) begin
          state_nxt_s = ST_CLEAR;
        end else if (hold_done_s) begin
          state_nxt_s    = ST_OVER;
          hold_cnt_nxt_s = hold_cnt_r;
        end else begin
          state_nxt_s    = ST_OVER;
          hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters, score registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      pipe_cnt_r    <= {PIPE_W{1'b0}};
      bird_cnt_r    <= {BIRD_W{1'b0}};
      hold_cnt_r    <= {HOLD_W{1'b0}};
      score_r       <= 12'h000;
      hi_score_r    <= 12'h000;
      point_q_r     <= 1'b0;
      run_r         <= 1'b0;
      game_over_r   <= 1'b0;
      clear_board_r <= 1'b0;
      pipe_tick_r   <= 1'b0;
      bird_tick_r   <= 1'b0;
      bird_up_r     <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      pipe_cnt_r    <= pipe_cnt_nxt_s;
      bird_cnt_r    <= bird_cnt_nxt_s;
      hold_cnt_r    <= hold_cnt_nxt_s;
      score_r       <= score_nxt_s;
      hi_score_r    <= hi_score_nxt_s;
      point_q_r     <= point;
      run_r         <= (state_nxt_s == ST_PLAY);
      game_over_r   <= (state_nxt_s == ST_OVER);
      clear_board_r <= (state_nxt_s == ST_CLEAR);
      pipe_tick_r   <= pipe_tick_nxt_s;
      bird_tick_r   <= bird_tick_nxt_s;
      bird_up_r     <= bird_up_nxt_s;
    end
  end

  assign run         = run_r;
  assign game_over   = game_over_r;
  assign clear_board = clear_board_r;
  assign pipe_tick   = pipe_tick_r;
  assign bird_tick   = bird_tick_r;
  assign bird_up     = bird_up_r;
  assign score       = score_r;
  assign hi_score    = hi_score_r;

  flappy_game_ctrl_chk u_chk (
    .clk         (clk),
    .reset       (reset),
    .run         (run_r),
    .game_over   (game_over_r),
    .clear_board (clear_board_r),
    .pipe_tick   (pipe_tick_r),
    .bird_tick   (bird_tick_r),
    .bird_up     (bird_up_r),
    .score       (score_r),
    .hi_score    (hi_score_r)
  );

endmodule

// Output invariants of the sequencer: the phase flags are exclusive, the
// clear pulse lasts one cycle, motion only happens in play, and the score
// registers hold valid BCD.
module flappy_game_ctrl_chk (
  input logic        clk,
  input logic        reset,
  input logic        run,
  input logic        game_over,
  input logic        clear_board,
  input logic        pipe_tick,
  input logic        bird_tick,
  input logic        bird_up,
  input logic [11:0] score,
  input logic [11:0] hi_score
);

  a_phase_onehot0: assert property (@(posedge clk) disable iff (reset)
    $onehot0({run, game_over, clear_board}));

  a_clear_single: assert property (@(posedge clk) disable iff (reset)
    clear_board |=> !clear_board);

  a_motion_in_play: assert property (@(posedge clk) disable iff (reset)
    (pipe_tick || bird_tick || bird_up) |-> run);

  a_flap_beats_gravity: assert property (@(posedge clk) disable iff (reset)
    bird_up |-> !bird_tick);

  a_score_bcd: assert property (@(posedge clk) disable iff (reset)
    (score[3:0] <= 4'd9) && (score[7:4] <= 4'd9) && (score[11:8] <= 4'd9));

  a_hi_bcd: assert property (@(posedge clk) disable iff (reset)
    (hi_score[3:0] <= 4'd9) && (hi_score[7:4] <= 4'd9) && (hi_score[11:8] <= 4'd9));

endmodule

// File: doc/flappy_game_ctrl.md
Name: flappy_game_ctrl

Overview:
Top-level game sequencer for the Flappy Bird board. It runs the IDLE/PLAY/OVER flow and generates the movement ticks that step the pipe and bird shifters. It consumes point/loser from the collision checker, keeps a 3-digit BCD score and a high score, and issues a one-cycle clear pulse. That pulse resets the collision checker and the board registers, because the checker's loser flag is sticky.

Parameters:
PIPE_DIV, 176, clk cycles per pipe_tick period (tick on count PIPE_DIV-1); sim value 8
BIRD_DIV, 100, clk cycles per bird_tick period (gravity step); sim value 4
OVER_HOLD, 512, cycles in OVER during which flap is ignored; sim value 4

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
flap  in  1  debounced single-cycle button pulse
point  in  1  from collision checker; bird cleared a pipe column
loser  in  1  from collision checker; bird hit a pipe (sticky until checker reset)
run  out  1  high while in PLAY
game_over  out  1  high while in OVER
clear_board  out  1  one-cycle pulse; resets collision checker, pipe and bird registers
pipe_tick  out  1  one-cycle pulse; advance pipes one column
bird_tick  out  1  one-cycle pulse; apply one gravity step
bird_up  out  1  one-cycle pulse; bird moves up one row
score  out  12  3 BCD digits {hundreds,tens,ones}
hi_score  out  12  3 BCD digits; best score since reset

Behaviour:
- Interface: single clock clk; reset is synchronous and active-high. All outputs are registered.
- Reset values: state IDLE; every output 0; score=0; hi_score=0; all internal counters 0; point-edge register 0.
- States: IDLE, CLEAR, PLAY, OVER.
- IDLE:
  - run=0; no ticks.
  - flap=1 -> CLEAR.
- CLEAR (exactly 1 cycle):
  - clear_board=1.
  - score<=0; pipe/bird dividers<=0.
  - Next state PLAY unconditionally. flap is ignored in this cycle.
- PLAY:
  - run=1.
  - Pipe divider counts 0..PIPE_DIV-1 and wraps. pipe_tick=1 on the cycle after the counter equals PIPE_DIV-1. bird_tick is generated the same way from BIRD_DIV.
  - The first pipe_tick comes PIPE_DIV cycles after entering PLAY.
  - flap=1 -> bird_up=1 next cycle, and the bird divider reloads to 0 (no gravity step right after a flap).
  - If flap coincides with a bird divider wrap, the flap wins: bird_up=1, bird_tick=0.
  - Scoring is on the rising edge of point (point=1 and its previous value 0):
    - Increment score BCD: ones 9->0 with carry into tens, tens 9->0 with carry into hundreds.
    - At 999 score saturates and does not wrap.
  - loser=1 -> OVER next cycle. loser has priority over point in the same cycle: no increment.
- OVER:
  - game_over=1; run=0; no ticks; no bird_up; score frozen.
  - On the PLAY->OVER transition cycle: if score > hi_score (BCD compare, equivalent to binary compare digitwise MSD first), hi_score<=score.
  - The hold counter starts at 0 on entry. flap is ignored while hold < OVER_HOLD.
  - After the hold, flap=1 -> CLEAR. hi_score is kept; score is cleared in CLEAR.
- Reset mid-operation: in any state, reset forces IDLE and clears hi_score and all counters that cycle. No clear_board pulse is generated by reset itself; the downstream blocks share reset.
- point and loser are ignored outside PLAY. The point-edge register still tracks point every cycle, so a point held high across CLEAR->PLAY scores nothing.
- Widths:
  - Divider widths are $clog2 of the parameter.
  - The hold counter is $clog2(OVER_HOLD)+1 bits and saturates at OVER_HOLD.

Test Plan:
- Use sim params (PIPE_DIV=8, BIRD_DIV=4, OVER_HOLD=4) for all scenarios.
- Reset, then idle for 20 cycles with no flap -> run=0, all ticks 0, score=12'h000, hi_score=12'h000.
- flap pulse in IDLE -> clear_board=1 for exactly 1 cycle, then run=1. pipe_tick pulses every 8 cycles and bird_tick every 4; first pipe_tick is 8 cycles after run rises.
- In PLAY, point held high 3 cycles, then low, repeated 12 times -> score=12'h012 (one increment per rising edge). Preload 999 via 999 edges -> a further edge keeps score=12'h999.
- point=1 and loser=1 in the same cycle with score=12'h005 -> next cycle game_over=1, score stays 12'h005, hi_score becomes 12'h005.
- In OVER, flap at hold cycle 2 -> ignored, game_over still 1. flap at hold cycle 5 -> clear_board pulse, score=12'h000, hi_score=12'h005. A next game ending at 12'h003 -> hi_score stays 12'h005.
- Assert reset mid-PLAY with score=12'h010 -> next cycle state IDLE, run=0, score=12'h000, hi_score=12'h000, no ticks. Also check flap coinciding with a bird divider wrap -> bird_up=1, bird_tick=0.
